// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame layout, scan-code constants, parity check.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Frame as it sits in the shift register once fully received (LSB = start).
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// 8-bit first-word-fall-through sync FIFO; extra pointer MSB separates full from empty.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [AW:0]           wptr, rptr;
    logic                  do_push, do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty head reads 0 so nothing stale leaks onto the output bus.
    assign rdata = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit deframer with timeout, FWFT byte FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overflow
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic                  fe;
    logic [FRAME_BITS-1:0] shreg;
    ps2_frame_t            frame_next;
    logic [3:0]            bit_cnt;
    logic [TW-1:0]         tcnt;
    logic                  last_bit, frame_good, timed_out;
    logic                  push, pop, full, empty;

    // Bring the pins into clk; idle bus is high, so reset loads ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Falling edge seen between stages 3 and 2; data stage 2 lines up with it.
    assign fe = clk_sync[2] & ~clk_sync[1];

    // Word as it will look after this edge's shift, used to judge the frame on its last bit.
    assign frame_next = ps2_frame_t'({dat_sync[1], shreg[FRAME_BITS-1:1]});
    assign last_bit   = fe && (bit_cnt == 4'(FRAME_BITS - 1));
    assign frame_good = ~frame_next.start & frame_next.stop &
                        odd_parity_ok(frame_next.data, frame_next.parity);
    assign timed_out  = (bit_cnt != 4'd0) && (tcnt == TW'(TIMEOUT));

    assign pop  = ~empty & i_ready;
    assign push = last_bit & frame_good;

    // Shift in one bit per falling edge, LSB first.
    always_ff @(posedge clk) begin
        if (rst)     shreg <= '0;
        else if (fe) shreg <= frame_next;
    end

    // Bit counter: 0 is idle, 1..10 mid-frame; wraps on the final edge or on timeout.
    always_ff @(posedge clk) begin
        if (rst)            bit_cnt <= 4'd0;
        else if (fe)        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        else if (timed_out) bit_cnt <= 4'd0;
    end

    // Inactivity counter: only runs mid-frame and restarts on every falling edge.
    always_ff @(posedge clk) begin
        if (rst)                                tcnt <= '0;
        else if (fe || bit_cnt == 4'd0)         tcnt <= '0;
        else if (timed_out)                     tcnt <= '0;
        else                                    tcnt <= tcnt + 1'b1;
    end

    // Error pulse one cycle after a bad frame; overflow latches until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_frame_err <= last_bit & ~frame_good;
            if (push && full && !pop) o_overflow <= 1'b1;
        end
    end

    ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (frame_next.data),
        .pop   (pop),
        .rdata (o_data),
        .full  (full),
        .empty (empty)
    );

    assign o_valid = ~empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: bit-banged PS/2 frames, expected bytes queued on send.
module tb_ps2_kbd_rx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int H       = 4;   // clk cycles per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overflow;

    int         vectors = 0;
    int         miscompares = 0;
    int         err_cnt = 0;
    logic [7:0] q[$];
    logic       exp_ovf = 1'b0;

    ps2_kbd_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    // Count cycles with the error pulse high, sampled mid-cycle.
    always @(negedge clk) if (o_frame_err === 1'b1) err_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        ps2_data = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) drive_bit(f[i]);
    endtask

    // Send a frame with i_ready low and record what the receiver should end up holding.
    task automatic send_frame(input logic [7:0] d, input logic bad);
        send_bits(frame_of(d, bad), 11);
        tick(2);
        if (!bad) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        i_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        tick(1);
    endtask

    // Pop everything, comparing each head against the scoreboard.
    task automatic drain(input string name);
        int budget;
        logic [7:0] exp;
        budget = 4 * DEPTH + 4;
        i_ready = 1'b1;
        while (o_valid === 1'b1 && budget > 0) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL %s_extra: got %02h want no data", name, o_data);
            end else begin
                exp = q.pop_front();
                if (o_data !== exp) begin
                    miscompares++;
                    $display("FAIL %s_data: got %02h want %02h", name, o_data, exp);
                end
            end
            tick(1);
            budget--;
        end
        i_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: got o_valid=%b want 0, %0d bytes never seen", name, o_valid, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({o_valid, o_data, o_frame_err, o_overflow} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset: got v=%b d=%02h e=%b o=%b want all 0", o_valid, o_data, o_frame_err, o_overflow);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_good_latency();
        logic [10:0] f;
        int e0;
        e0 = err_cnt;
        f = frame_of(8'h1C, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        tick(H);
        ps2_clk = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            vectors++;
            if (o_valid !== (k == 3)) begin
                miscompares++;
                $display("FAIL latency_e%0d: got o_valid=%b want %b", k, o_valid, (k == 3));
            end
        end
        q.push_back(8'h1C);
        vectors++;
        if (o_data !== 8'h1C) begin
            miscompares++;
            $display("FAIL good_data: got %02h want 1c", o_data);
        end
        ps2_clk = 1'b1;
        tick(6);
        vectors++;
        if (o_data !== 8'h1C || o_valid !== 1'b1 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL good_hold: got d=%02h v=%b errs=%0d want 1c 1 0", o_data, o_valid, err_cnt - e0);
        end
        drain("good");
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        tick(3);
        vectors++;
        if (err_cnt - e0 != 1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_err: got pulse_cycles=%0d o_valid=%b want 1 0", err_cnt - e0, o_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0);
            if (i == 8) begin
                vectors++;
                if (o_overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_early: got %b want 0", o_overflow);
                end
            end
        end
        vectors++;
        if (o_overflow !== exp_ovf) begin
            miscompares++;
            $display("FAIL ovf_set: got %b want %b", o_overflow, exp_ovf);
        end
        drain("ovf");
        vectors++;
        if (o_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got %b want 1", o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [10:0] f;
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
        f = frame_of(8'h0A, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        tick(H);
        ps2_clk = 1'b0;
        tick(2);
        i_ready = 1'b1;
        vectors++;
        if (o_data !== q[0]) begin
            miscompares++;
            $display("FAIL fpp_head: got %02h want %02h", o_data, q[0]);
        end
        tick(1);
        i_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h0A);
        vectors++;
        if (o_overflow !== 1'b0 || o_valid !== 1'b1 || o_data !== q[0]) begin
            miscompares++;
            $display("FAIL fpp_state: got ovf=%b v=%b d=%02h want 0 1 %02h", o_overflow, o_valid, o_data, q[0]);
        end
        tick(H);
        ps2_clk = 1'b1;
        tick(H);
        drain("fpp");
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bits(frame_of(8'h55, 1'b0), 5);
        tick(TIMEOUT + 2);
        send_frame(8'hF0, 1'b0);
        tick(2);
        vectors++;
        if (o_data !== 8'hF0 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL timeout: got d=%02h errs=%0d want f0 0", o_data, err_cnt - e0);
        end
        drain("timeout");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_bits(frame_of(8'h1C, 1'b0), 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        vectors++;
        if (o_valid !== 1'b0 || o_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid: got v=%b d=%02h want 0 00", o_valid, o_data);
        end
        tick(2);
        send_frame(8'h32, 1'b0);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 8'h32) begin
            miscompares++;
            $display("FAIL rst_after: got v=%b d=%02h want 1 32", o_valid, o_data);
        end
        drain("rst");
    endtask

    initial begin
        test_reset();
        test_good_latency();
        test_parity_err();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
